// File: rtl/linproj_out_serializer.sv
// linproj_out_serializer
//   Captures wide matmul result snapshots into a small FIFO and replays each
//   one as a narrow valid/ready beat stream: block 0 first, LSB slice first
//   within a block. Snapshots may be tagged as end-of-frame; frame_done
//   pulses one cycle after the last beat of a tagged snapshot is accepted.
//
// Ports
//   clk, rst     : single clock, asynchronous active-high reset
//   in_valid     : one-cycle pulse, in_data holds a new snapshot
//   in_data      : NUM_BLOCKS*BLOCK_WIDTH snapshot, block k at [k*BLOCK_WIDTH +: BLOCK_WIDTH]
//   in_done      : end-of-frame marker (tags the new or newest pending snapshot)
//   m_valid      : beat available
//   m_data       : OUT_WIDTH beat payload
//   m_last       : final beat of a snapshot
//   m_ready      : consumer accepts beat
//   frame_done   : one-cycle pulse, frame fully streamed
//   overflow     : sticky, a snapshot was dropped because the FIFO was full
//   drop_count   : dropped snapshots, saturating at 255
module linproj_out_serializer #(
  parameter int unsigned NUM_BLOCKS  = 4,
  parameter int unsigned BLOCK_WIDTH = 256,
  parameter int unsigned OUT_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [NUM_BLOCKS*BLOCK_WIDTH-1:0] in_data,
  input  logic                              in_done,
  output logic                              m_valid,
  output logic [OUT_WIDTH-1:0]              m_data,
  output logic                              m_last,
  input  logic                              m_ready,
  output logic                              frame_done,
  output logic                              overflow,
  output logic [7:0]                        drop_count
);

  localparam int unsigned SNAP_W = NUM_BLOCKS * BLOCK_WIDTH;
  localparam int unsigned BEATS  = BLOCK_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] f_beat(input logic [SNAP_W-1:0] snap,
                                                  input logic [BLK_W-1:0]  blk,
                                                  input logic [BEAT_W-1:0] beat);
    int unsigned off;
    off = 32'(blk) * BLOCK_WIDTH + 32'(beat) * OUT_WIDTH;
    return snap[off +: OUT_WIDTH];
  endfunction

  function automatic logic f_is_last(input logic [BLK_W-1:0] blk, input logic [BEAT_W-1:0] beat);
    return (blk == BLK_W'(NUM_BLOCKS - 1)) && (beat == BEAT_W'(BEATS - 1));
  endfunction

  logic [SNAP_W-1:0]     r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_tag;
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count;
  state_t                r_state;
  logic                  r_m_valid, r_m_last, r_frame_done, r_overflow;
  logic [OUT_WIDTH-1:0]  r_m_data;
  logic [BLK_W-1:0]      r_blk;
  logic [BEAT_W-1:0]     r_beat;
  logic [7:0]            r_drop_count;

  logic                  w_hs, w_pop, w_full, w_push, w_drop, w_tag_newest, w_load;
  logic [CNT_W-1:0]      w_remain;
  logic [PTR_W-1:0]      w_rptr_nx, w_newest;
  logic [SNAP_W-1:0]     w_snap;
  state_t                w_state_d;
  logic                  w_valid_d, w_last_d;
  logic [OUT_WIDTH-1:0]  w_data_d;
  logic [BLK_W-1:0]      w_blk_d;
  logic [BEAT_W-1:0]     w_beat_d;

  // The head entry stays in the FIFO until its final beat is accepted, so a
  // pop is exactly a final-beat handshake; fullness is judged after that pop.
  assign w_hs         = r_m_valid && m_ready;
  assign w_pop        = w_hs && r_m_last;
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH)) && !w_pop;
  assign w_push       = in_valid && !w_full;
  assign w_drop       = in_valid && w_full;
  assign w_remain     = r_count - CNT_W'(w_pop);
  assign w_rptr_nx    = f_ptr_inc(r_rptr);
  assign w_newest     = (r_wptr == '0) ? PTR_W'(FIFO_DEPTH - 1) : r_wptr - PTR_W'(1);
  // A done marker that does not land on a newly captured snapshot (alone, or
  // riding a dropped one) tags the newest snapshot still pending.
  assign w_tag_newest = in_done && !w_push && (w_remain != '0);

  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_m_valid;
    w_data_d  = r_m_data;
    w_last_d  = r_m_last;
    w_blk_d   = r_blk;
    w_beat_d  = r_beat;
    w_snap    = r_mem[r_rptr];
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_d = S_STREAM;
          w_valid_d = 1'b1;
          w_blk_d   = '0;
          w_beat_d  = '0;
          w_load    = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          w_load = 1'b1;
          if (r_m_last) begin
            // Next head (if any) is presented on the same edge: no bubble.
            w_blk_d  = '0;
            w_beat_d = '0;
            w_snap   = r_mem[w_rptr_nx];
            if (w_remain == '0) begin
              w_state_d = S_IDLE;
              w_valid_d = 1'b0;
            end
          end else if (r_beat == BEAT_W'(BEATS - 1)) begin
            w_beat_d = '0;
            w_blk_d  = r_blk + BLK_W'(1);
          end else begin
            w_beat_d = r_beat + BEAT_W'(1);
          end
        end
      end
      default: w_state_d = S_IDLE;
    endcase
    if (w_load) begin
      w_data_d = w_valid_d ? f_beat(w_snap, w_blk_d, w_beat_d) : '0;
      w_last_d = w_valid_d && f_is_last(w_blk_d, w_beat_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_blk     <= '0;
      r_beat    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_m_valid <= w_valid_d;
      r_m_data  <= w_data_d;
      r_m_last  <= w_last_d;
      r_blk     <= w_blk_d;
      r_beat    <= w_beat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_tag        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= in_done;
        r_wptr        <= f_ptr_inc(r_wptr);
      end else if (w_tag_newest) begin
        r_tag[w_newest] <= 1'b1;
      end
      if (w_pop) r_rptr <= w_rptr_nx;
      r_count      <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_frame_done <= (w_pop && r_tag[r_rptr]) || (in_done && !w_push && (w_remain == '0));
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

endmodule
